// File: rtl/wavelet_frame_ctrl.sv
// Frame sequencer for a db_wavelet instance: clears the filter, streams one
// frame of samples into it, appends a zero tail, drains the remaining
// outputs and forwards every captured |coefficient| as an envelogram sample.
module wavelet_frame_ctrl #(
    parameter int N_LEVEL   = 3,
    parameter int LEN_W     = 16,
    parameter int CLR_CYC   = 2,
    parameter int FLUSH_LEN = 64,
    parameter int DRAIN_LEN = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] frame_len,
    input  logic             in_valid,
    input  logic [31:0]      in_data,
    output logic             in_ready,
    output logic [31:0]      wv_data,
    output logic             wv_rst,
    input  logic [31:0]      wv_abs,
    input  logic             wv_we,
    output logic             out_valid,
    output logic [31:0]      out_data,
    output logic [LEN_W-1:0] out_count,
    output logic             busy,
    output logic             done,
    output logic             err
);

    // The decomposition depth only configures the wavelet itself; a
    // non-positive value is meaningless for the attached filter.
    if (N_LEVEL < 1) begin : g_n_level_invalid
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_STREAM,
        S_FLUSH,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t             state;
    state_t             next_state;
    logic [31:0]        phase_cnt;   // cycles spent in the current timed state
    logic [LEN_W-1:0]   remain;      // samples still expected in STREAM
    logic               accept;      // start taken in IDLE
    logic               capture;     // wavelet output to forward next cycle
    logic               err_next;

    // Next-state decode plus the single-cycle event flags.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves it unassigned, which would otherwise infer a latch.
        next_state = state;
        accept     = 1'b0;
        err_next   = 1'b0;
        capture    = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    if (frame_len != '0) begin
                        accept     = 1'b1;
                        next_state = S_CLEAR;
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end
            S_CLEAR: begin
                if (phase_cnt == 32'(CLR_CYC - 1)) next_state = S_STREAM;
            end
            S_STREAM: begin
                capture = wv_we;
                if (!in_valid) begin
                    err_next   = 1'b1;
                    next_state = S_IDLE;
                end else if (remain == LEN_W'(1)) begin
                    next_state = S_FLUSH;
                end
            end
            S_FLUSH: begin
                capture = wv_we;
                if (phase_cnt == 32'(FLUSH_LEN - 1)) next_state = S_DRAIN;
            end
            S_DRAIN: begin
                capture = wv_we;
                if (phase_cnt == 32'(DRAIN_LEN - 1)) next_state = S_DONE;
            end
            S_DONE: begin
                next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    // State, counters and registered datapath outputs.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments here so every register samples the
        // pre-edge values, independent of statement order.
        if (rst) begin
            state     <= S_IDLE;
            phase_cnt <= '0;
            remain    <= '0;
            wv_data   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_count <= '0;
            err       <= 1'b0;
        end else begin
            state     <= next_state;
            phase_cnt <= (next_state != state) ? '0 : phase_cnt + 32'd1;
            err       <= err_next;
            out_valid <= capture;

            if (accept) begin
                remain <= frame_len;
            end else if (state == S_STREAM && in_valid) begin
                remain <= remain - LEN_W'(1);
            end

            // Only accepted source samples reach the filter; zeros otherwise.
            wv_data <= (state == S_STREAM && in_valid) ? in_data : '0;

            if (capture) out_data <= wv_abs;

            if (accept) begin
                out_count <= '0;
            end else if (capture && out_count != '1) begin
                out_count <= out_count + LEN_W'(1);
            end
        end
    end

    // Status outputs decoded directly from the state register.
    always_comb begin
        in_ready = (state == S_STREAM);
        busy     = (state != S_IDLE);
        done     = (state == S_DONE);
        wv_rst   = rst | (state == S_CLEAR);
    end

endmodule

// File: tb/tb_wavelet_frame_ctrl.sv
// Directed bench for wavelet_frame_ctrl: nominal frame, rejected start,
// underrun, start-while-busy, reset mid-flush and out_count saturation.
module tb_wavelet_frame_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] frame_len;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic [31:0] wv_data;
    logic        wv_rst;
    logic [31:0] wv_abs;
    logic        wv_we;
    logic        out_valid;
    logic [31:0] out_data;
    logic [15:0] out_count;
    logic        busy;
    logic        done;
    logic        err;

    // Small-counter instance for the saturation case.
    logic        start_s;
    logic [3:0]  frame_len_s;
    logic        wv_we_s;
    logic        in_ready_s;
    logic [31:0] wv_data_s;
    logic        wv_rst_s;
    logic        out_valid_s;
    logic [31:0] out_data_s;
    logic [3:0]  out_count_s;
    logic        busy_s;
    logic        done_s;
    logic        err_s;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    wavelet_frame_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .frame_len(frame_len),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .wv_data(wv_data), .wv_rst(wv_rst), .wv_abs(wv_abs), .wv_we(wv_we),
        .out_valid(out_valid), .out_data(out_data), .out_count(out_count),
        .busy(busy), .done(done), .err(err)
    );

    wavelet_frame_ctrl #(.LEN_W(4), .FLUSH_LEN(8), .DRAIN_LEN(4)) dut_s (
        .clk(clk), .rst(rst), .start(start_s), .frame_len(frame_len_s),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready_s),
        .wv_data(wv_data_s), .wv_rst(wv_rst_s), .wv_abs(wv_abs), .wv_we(wv_we_s),
        .out_valid(out_valid_s), .out_data(out_data_s), .out_count(out_count_s),
        .busy(busy_s), .done(done_s), .err(err_s)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ramp(input int c);
        return 32'hFFFF_FFC0 + 32'(c);
    endfunction

    initial begin
        int          e_rst, e_rdy, e_dat, e_busy, e_err, e_ov, e_od;
        int          n_done, done_cyc, n_err;
        logic        prev_we, exp_ov;
        logic [31:0] prev_abs;

        rst = 1'b1; start = 1'b0; frame_len = '0; in_valid = 1'b0;
        in_data = '0; wv_abs = '0; wv_we = 1'b0;
        start_s = 1'b0; frame_len_s = '0; wv_we_s = 1'b0;

        // ---------------- reset state ----------------
        tick(); tick();
        check("rst_wv_rst",    32'(wv_rst),    32'd1);
        check("rst_wv_data",   wv_data,        32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data",  out_data,       32'd0);
        check("rst_out_count", 32'(out_count), 32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_done",      32'(done),      32'd0);
        check("rst_err",       32'(err),       32'd0);
        rst = 1'b0;
        tick();
        check("idle_wv_rst",   32'(wv_rst),    32'd0);

        // ---------------- nominal 100-sample frame ----------------
        e_rst = 0; e_rdy = 0; e_dat = 0; e_busy = 0; e_err = 0; e_ov = 0; e_od = 0;
        n_done = 0; done_cyc = 0; prev_we = 1'b0; prev_abs = '0;
        start = 1'b1; frame_len = 16'd100; in_valid = 1'b1; in_data = ramp(0);
        tick();
        start = 1'b0;
        for (int c = 1; c <= 186; c++) begin
            if (wv_rst !== (c <= 2)) e_rst++;
            if (in_ready !== (c >= 3 && c <= 102)) e_rdy++;
            if (wv_data !== ((c >= 4 && c <= 103) ? ramp(c - 1) : 32'd0)) e_dat++;
            if (busy !== (c <= 183)) e_busy++;
            if (err !== 1'b0) e_err++;
            if (done) begin
                n_done++;
                if (done_cyc == 0) done_cyc = c;
            end
            exp_ov = prev_we && (c - 1 >= 3) && (c - 1 <= 182);
            if (out_valid !== exp_ov) e_ov++;
            if (exp_ov && out_data !== prev_abs) e_od++;
            in_data  = ramp(c);
            wv_we    = (c % 3 == 0) || (c <= 2) || (c >= 183);
            wv_abs   = 32'hA5A5_0000 ^ 32'(c);
            prev_we  = wv_we;
            prev_abs = wv_abs;
            tick();
        end
        check("t1_wv_rst_window",  32'(e_rst),  32'd0);
        check("t1_in_ready_window",32'(e_rdy),  32'd0);
        check("t1_wv_data_stream", 32'(e_dat),  32'd0);
        check("t1_busy_window",    32'(e_busy), 32'd0);
        check("t1_no_err",         32'(e_err),  32'd0);
        check("t1_out_valid",      32'(e_ov),   32'd0);
        check("t1_out_data",       32'(e_od),   32'd0);
        check("t1_done_cycle",     32'(done_cyc), 32'd183);
        check("t1_done_count",     32'(n_done), 32'd1);
        check("t1_out_count",      32'(out_count), 32'd60);
        check("t1_idle_out_valid", 32'(out_valid), 32'd0);
        wv_we = 1'b0;

        // ---------------- zero-length start ----------------
        start = 1'b1; frame_len = 16'd0;
        tick();
        start = 1'b0;
        check("t2_err_pulse", 32'(err),    32'd1);
        check("t2_busy",      32'(busy),   32'd0);
        check("t2_wv_rst",    32'(wv_rst), 32'd0);
        tick();
        check("t2_err_clear", 32'(err),    32'd0);
        check("t2_busy_after",32'(busy),   32'd0);

        // ---------------- underrun at sample 20 ----------------
        n_done = 0; n_err = 0;
        start = 1'b1; frame_len = 16'd50; in_valid = 1'b1; wv_we = 1'b1;
        tick();
        start = 1'b0;
        check("t3_count_cleared", 32'(out_count), 32'd0);
        for (int c = 1; c <= 30; c++) begin
            if (err) n_err++;
            if (done) n_done++;
            if (c == 24) begin
                check("t3_err_at_abort",   32'(err),       32'd1);
                check("t3_idle_at_abort",  32'(busy),      32'd0);
                check("t3_wv_data_zero",   wv_data,        32'd0);
                check("t3_count_at_abort", 32'(out_count), 32'd21);
            end
            in_valid = (c != 23);
            tick();
        end
        check("t3_single_err", 32'(n_err),     32'd1);
        check("t3_no_done",    32'(n_done),    32'd0);
        check("t3_count_held", 32'(out_count), 32'd21);
        wv_we = 1'b0;

        // ---------------- start while busy ----------------
        n_done = 0; n_err = 0; done_cyc = 0;
        start = 1'b1; frame_len = 16'd10; in_valid = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 100; c++) begin
            if (err) n_err++;
            if (done) begin
                n_done++;
                if (done_cyc == 0) done_cyc = c;
            end
            start     = (c == 5);
            frame_len = (c == 5) ? 16'd3 : 16'd10;
            tick();
        end
        start = 1'b0;
        check("t4_done_cycle", 32'(done_cyc), 32'd93);
        check("t4_single_done",32'(n_done),   32'd1);
        check("t4_no_err",     32'(n_err),    32'd0);

        // ---------------- reset during FLUSH ----------------
        start = 1'b1; frame_len = 16'd5; wv_we = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c < 20; c++) tick();
        check("t5_pre_in_ready", 32'(in_ready),  32'd0);
        check("t5_pre_count",    32'(out_count), 32'd17);
        rst = 1'b1;
        tick();
        check("t5_wv_rst",    32'(wv_rst),    32'd1);
        check("t5_wv_data",   wv_data,        32'd0);
        check("t5_in_ready",  32'(in_ready),  32'd0);
        check("t5_out_valid", 32'(out_valid), 32'd0);
        check("t5_out_data",  out_data,       32'd0);
        check("t5_out_count", 32'(out_count), 32'd0);
        check("t5_busy",      32'(busy),      32'd0);
        check("t5_done",      32'(done),      32'd0);
        check("t5_err",       32'(err),       32'd0);
        n_done = 0; done_cyc = 0;
        rst = 1'b0; start = 1'b1; frame_len = 16'd4;
        tick();
        start = 1'b0;
        check("t5_restart_busy", 32'(busy), 32'd1);
        for (int c = 1; c <= 100; c++) begin
            if (done) begin
                n_done++;
                if (done_cyc == 0) done_cyc = c;
            end
            tick();
        end
        check("t5_done_cycle", 32'(done_cyc),  32'd87);
        check("t5_single_done",32'(n_done),    32'd1);
        check("t5_out_count",  32'(out_count), 32'd84);
        wv_we = 1'b0;

        // ---------------- saturation with LEN_W=4 ----------------
        n_done = 0; done_cyc = 0;
        start_s = 1'b1; frame_len_s = 4'd6; wv_we_s = 1'b1; in_valid = 1'b1;
        tick();
        start_s = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            if (done_s) begin
                n_done++;
                if (done_cyc == 0) done_cyc = c;
            end
            tick();
        end
        check("t6_done_cycle", 32'(done_cyc),    32'd21);
        check("t6_saturated",  32'(out_count_s), 32'd15);
        check("t6_no_err",     32'(err_s),       32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
